// File: rtl/serial_para_frame.sv
`default_nettype none
// ============================================================================
// Module   : serial_para_frame
// Brief    : Serial-to-parallel frame collector for the NTT datapath.
//            Gathers DEPTH coefficients, one per handshake, into a single
//            parallel frame held in a registered output buffer with
//            valid/ready flow control. An optional bit-reversed lane order
//            lets the frame feed butterfly stages directly.
//            All state updates on the falling edge of clock.
// Revision : 1.0 - initial release
// ============================================================================
module serial_para_frame #(
   parameter int WIDTH  = 18,
   parameter int DEPTH  = 8,
   parameter int BITREV = 0
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [DEPTH*WIDTH-1:0]     out_para,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH)-1:0]   fill_cnt
);

   localparam int CW = $clog2(DEPTH);
   localparam logic [CW-1:0] c_LAST = CW'(DEPTH - 1);

   logic [WIDTH-1:0]       r_cap [DEPTH];
   logic [CW-1:0]          r_fill;
   logic [DEPTH*WIDTH-1:0] r_out;
   logic                   r_valid;

   logic                   w_last;
   logic                   w_ready;
   logic                   w_acc;
   logic [CW-1:0]          w_lane;
   logic [DEPTH*WIDTH-1:0] w_frame;

   // The final sample is the only one that can stall: it needs the output
   // buffer to be empty or being drained on the same edge.
   always_comb begin
      w_last  = (r_fill == c_LAST);
      w_ready = reset_n && !(w_last && r_valid && !out_ready);
      w_acc   = in_valid && w_ready && !flush;
   end

   // Destination lane of the current sample, optionally bit-reversed.
   always_comb begin
      w_lane = '0;
      for (int b = 0; b < CW; b++) begin
         w_lane[b] = (BITREV != 0) ? r_fill[CW-1-b] : r_fill[b];
      end
   end

   // Full frame as it would look with the current sample merged in; only
   // ever captured into r_out, so in_data never reaches out_para directly.
   always_comb begin
      w_frame = '0;
      for (int l = 0; l < DEPTH; l++) begin
         w_frame[l*WIDTH +: WIDTH] = r_cap[l];
      end
      w_frame[int'(w_lane)*WIDTH +: WIDTH] = in_data;
   end

   // Capture buffer, fill counter and double-buffered output frame.
   always_ff @(negedge clock) begin
      if (!reset_n) begin
         for (int l = 0; l < DEPTH; l++) begin
            r_cap[l] <= '0;
         end
         r_fill  <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
      end else begin
         if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
         if (flush) begin
            r_fill <= '0;
         end else if (w_acc) begin
            if (w_last) begin
               r_out   <= w_frame;
               r_valid <= 1'b1;
               r_fill  <= '0;
            end else begin
               r_cap[w_lane] <= in_data;
               r_fill        <= r_fill + 1'b1;
            end
         end
      end
   end

   assign in_ready  = w_ready;
   assign out_para  = r_out;
   assign out_valid = r_valid;
   assign fill_cnt  = r_fill;

endmodule
`default_nettype wire

// File: tb/tb_serial_para_frame.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_para_frame
// Brief    : Scoreboard bench for serial_para_frame. Two instances (natural
//            and bit-reversed lane order) share one stimulus stream; a
//            frame-level reference model pushes expected frames into queues
//            and a monitor compares them when frames are presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_para_frame;

   localparam int W  = 18;
   localparam int D  = 8;
   localparam int FW = W * D;

   logic          clock;
   logic          reset_n;
   logic          flush;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          out_ready;

   logic          rdy0, rdy1, val0, val1;
   logic [FW-1:0] para0, para1;
   logic [2:0]    fill0, fill1;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int            m_cnt   = 0;
   bit            m_valid = 1'b0;
   bit            m_zero  = 1'b1;
   int            m_samp [D];
   logic [FW-1:0] q0 [$];
   logic [FW-1:0] q1 [$];

   serial_para_frame #(.WIDTH(W), .DEPTH(D), .BITREV(0)) u_nat (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
      .out_para(para0), .out_valid(val0), .out_ready(out_ready),
      .fill_cnt(fill0)
   );

   serial_para_frame #(.WIDTH(W), .DEPTH(D), .BITREV(1)) u_rev (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
      .out_para(para1), .out_valid(val1), .out_ready(out_ready),
      .fill_cnt(fill1)
   );

   initial clock = 1'b1;
   always #5 clock = ~clock;

   function automatic int rev3(input int k);
      int r = 0;
      for (int b = 0; b < 3; b++) r = r * 2 + ((k / (2 ** b)) % 2);
      return r;
   endfunction

   task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Frame-level model: count samples, emit whole frames.
   always @(negedge clock) begin : model
      bit rdy;
      bit acc;
      logic [FW-1:0] f0, f1;
      if (!reset_n) begin
         m_cnt   = 0;
         m_valid = 1'b0;
         m_zero  = 1'b1;
         q0.delete();
         q1.delete();
      end else begin
         rdy = !(m_cnt == D - 1 && m_valid && !out_ready);
         acc = in_valid && rdy && !flush;
         if (m_valid && out_ready) m_valid = 1'b0;
         if (flush) begin
            m_cnt = 0;
         end else if (acc) begin
            m_samp[m_cnt] = int'(in_data);
            if (m_cnt == D - 1) begin
               f0 = '0;
               f1 = '0;
               for (int k = 0; k < D; k++) begin
                  f0[k*W +: W]       = W'(m_samp[k]);
                  f1[rev3(k)*W +: W] = W'(m_samp[k]);
               end
               q0.push_back(f0);
               q1.push_back(f1);
               m_valid = 1'b1;
               m_zero  = 1'b0;
               m_cnt   = 0;
            end else begin
               m_cnt++;
            end
         end
      end
   end

   // Monitor: sample 1 time unit after the rising edge, mid-cycle.
   initial begin : monitor
      bit exp_rdy;
      forever begin
         @(posedge clock);
         #1;
         exp_rdy = reset_n && !(m_cnt == D - 1 && m_valid && !out_ready);
         chk("in_ready_nat", FW'(rdy0), FW'(exp_rdy));
         chk("in_ready_rev", FW'(rdy1), FW'(exp_rdy));
         chk("out_valid_nat", FW'(val0), FW'(m_valid));
         chk("out_valid_rev", FW'(val1), FW'(m_valid));
         chk("fill_cnt_nat", FW'(fill0), FW'(m_cnt));
         chk("fill_cnt_rev", FW'(fill1), FW'(m_cnt));
         if (m_zero) begin
            chk("out_para_reset_nat", para0, '0);
            chk("out_para_reset_rev", para1, '0);
         end
         if (m_valid) begin
            if (q0.size() == 0 || q1.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL scoreboard_empty at %0t: got no expected frame, required one", $time);
            end else begin
               chk("frame_nat", para0, q0[0]);
               chk("frame_rev", para1, q1[0]);
               if (out_ready && reset_n) begin
                  void'(q0.pop_front());
                  void'(q1.pop_front());
               end
            end
         end
      end
   end

   task automatic step(input bit rn, input bit fl, input bit iv,
                       input logic [W-1:0] d, input bit ordy);
      reset_n   = rn;
      flush     = fl;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      @(posedge clock);
   endtask

   initial begin : driver
      reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      // Reset
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      repeat (2) step(1, 0, 0, 0, 1);
      // Natural order, samples 1..8
      for (int i = 1; i <= 8; i++) step(1, 0, 1, W'(i), 1);
      repeat (3) step(1, 0, 0, 0, 1);
      // Bit-reversed check, samples 0..7
      for (int i = 0; i < 8; i++) step(1, 0, 1, W'(i), 1);
      repeat (3) step(1, 0, 0, 0, 1);
      // Backpressure: frame 1 held while frame 2 fills, last sample stalls
      for (int i = 0; i < 15; i++) step(1, 0, 1, W'(200 + i), 0);
      repeat (3) step(1, 0, 1, W'(215), 0);
      step(1, 0, 1, W'(215), 1);
      repeat (3) step(1, 0, 0, 0, 1);
      // Flush discards a partial frame
      for (int i = 0; i < 5; i++) step(1, 0, 1, W'(50 + i), 1);
      step(1, 1, 1, W'(77), 1);
      for (int i = 0; i < 8; i++) step(1, 0, 1, W'(100 + i), 1);
      repeat (3) step(1, 0, 0, 0, 1);
      // Mid-frame reset
      for (int i = 0; i < 3; i++) step(1, 0, 1, W'(10 + i), 1);
      step(0, 0, 1, W'(99), 1);
      for (int i = 0; i < 8; i++) step(1, 0, 1, W'(20 + i), 1);
      repeat (3) step(1, 0, 0, 0, 1);
      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         step(($urandom % 150) != 0,
              ($urandom % 25) == 0,
              ($urandom % 4) != 0,
              W'($urandom),
              ($urandom % 3) != 0);
      end
      repeat (4) step(1, 0, 0, 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
